// File: rtl/pcw_io_pkg.sv
// Shared definitions for the PCW I/O port decoders: port codes, port
// addresses and the daisywheel I/O-cycle state encoding.
package pcw_io_pkg;

  typedef enum logic [1:0] {
    PORT_FC  = 2'b00,
    PORT_FD  = 2'b01,
    PORT_1FC = 2'b10
  } daisy_port_t;

  localparam logic [15:0] ADDR_FC    = 16'h00FC;
  localparam logic [7:0]  ADDR_FD_LO = 8'hFD;
  localparam logic [15:0] ADDR_1FC   = 16'h01FC;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    HOLD
  } daisy_state_t;

endpackage

// File: rtl/io_port_match.sv
// Combinational decode of a Z80 I/O address onto the daisywheel port codes.
// 0x01FC is checked first; FC/FD otherwise match on the low byte only.
module io_port_match
  import pcw_io_pkg::*;
(
  input  logic [15:0] cpu_addr,
  output logic        hit,
  output daisy_port_t code
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    hit  = 1'b0;
    code = PORT_FC;
    if (cpu_addr == ADDR_1FC) begin
      hit  = 1'b1;
      code = PORT_1FC;
    end else if (cpu_addr[7:0] == ADDR_FC[7:0]) begin
      hit  = 1'b1;
      code = PORT_FC;
    end else if (cpu_addr[7:0] == ADDR_FD_LO) begin
      hit  = 1'b1;
      code = PORT_FD;
    end
  end

endmodule

// File: rtl/daisy_io_decoder.sv
// Z80 I/O-cycle tracker for the daisywheel controller: one stable select window
// per decoded IORQ cycle. Optional wait-state insertion via DAISY_WAIT_EN.
module daisy_io_decoder
  import pcw_io_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  output logic        sel,
  output logic [1:0]  address,
  output logic        wr,
  output logic [7:0]  din,
  input  logic [7:0]  daisy_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_hit,
  output logic        cpu_wait_n
);

  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("daisy_io_decoder: WAIT_STATES must be in 1..15");
  end

  daisy_state_t state;
  daisy_port_t  port_code;
  logic         port_hit;
  logic         armed;
  logic [7:0]   cpu_din_q;
  logic         start;

  io_port_match u_match (
    .cpu_addr (cpu_addr),
    .hit      (port_hit),
    .code     (port_code)
  );

  // Interrupt acknowledge (M1 low) and rd/wr both low never start a cycle.
  assign start = (state == IDLE) && !cpu_iorq_n && cpu_m1_n &&
                 (cpu_rd_n ^ cpu_wr_n) && port_hit && armed;

  assign cpu_din = cpu_hit ? cpu_din_q : 8'hFF;

`ifdef DAISY_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);
  logic [3:0] wait_cnt;
  logic       wait_n_q;
  assign cpu_wait_n = wait_n_q;
`else
  assign cpu_wait_n = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      address   <= PORT_FC;
      wr        <= 1'b0;
      din       <= 8'h00;
      cpu_din_q <= 8'hFF;
      cpu_hit   <= 1'b0;
      armed     <= 1'b0;
`ifdef DAISY_WAIT_EN
      wait_cnt  <= 4'd0;
      wait_n_q  <= 1'b1;
`endif
    end else if (ce) begin
      if (cpu_iorq_n) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCESS;
            sel     <= 1'b1;
            address <= port_code;
            wr      <= ~cpu_wr_n;
            if (!cpu_wr_n) din <= cpu_dout;
            armed   <= 1'b0;
          end
        end
        ACCESS: begin
          if (!wr) cpu_din_q <= daisy_dout;
          cpu_hit <= ~wr;
`ifdef DAISY_WAIT_EN
          state    <= WAIT;
          wait_cnt <= WAIT_LOAD;
          wait_n_q <= 1'b0;
`else
          state    <= HOLD;
`endif
        end
        WAIT: begin
`ifdef DAISY_WAIT_EN
          if (wait_cnt == 4'd0) begin
            state    <= HOLD;
            wait_n_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
`else
          state <= HOLD;
`endif
        end
        HOLD: begin
          // The window closes only once the CPU has released IORQ.
          if (cpu_iorq_n) begin
            state   <= IDLE;
            sel     <= 1'b0;
            cpu_hit <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_daisy_io_decoder.sv
// Self-checking bench for daisy_io_decoder: tick-counting reference model plus
// directed scenarios. Honours DAISY_WAIT_EN the same way as the design.
module tb_daisy_io_decoder;
  import pcw_io_pkg::*;

`ifdef DAISY_WAIT_EN
  localparam int WX = 3;
`else
  localparam int WX = 0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n;
  logic        sel;
  logic [1:0]  address;
  logic        wr;
  logic [7:0]  din;
  logic [7:0]  daisy_dout;
  logic [7:0]  cpu_din;
  logic        cpu_hit;
  logic        cpu_wait_n;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  daisy_io_decoder #(.WAIT_STATES(3)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_iorq_n (cpu_iorq_n),
    .cpu_rd_n   (cpu_rd_n),
    .cpu_wr_n   (cpu_wr_n),
    .cpu_m1_n   (cpu_m1_n),
    .sel        (sel),
    .address    (address),
    .wr         (wr),
    .din        (din),
    .daisy_dout (daisy_dout),
    .cpu_din    (cpu_din),
    .cpu_hit    (cpu_hit),
    .cpu_wait_n (cpu_wait_n)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clk_sys);
      ce = ~ce;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int port_of(input logic [15:0] a);
    if (a == 16'h01FC) return 2;
    if (a[7:0] == 8'hFC) return 0;
    if (a[7:0] == 8'hFD) return 1;
    return -1;
  endfunction

  bit         m_busy, m_armed, m_sel, m_wr, m_hit, m_wait_n;
  int         m_k;
  logic [1:0] m_addr;
  logic [7:0] m_din, m_cap;

  initial begin
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        m_busy = 0; m_k = 0; m_armed = 0; m_sel = 0; m_addr = 2'b00;
        m_wr = 0; m_din = 8'h00; m_cap = 8'hFF; m_hit = 0; m_wait_n = 1;
      end else if (ce) begin
        if (!m_busy) begin
          if (!cpu_iorq_n && cpu_m1_n && (cpu_rd_n != cpu_wr_n) &&
              port_of(cpu_addr) >= 0 && m_armed) begin
            m_busy = 1; m_k = 0; m_sel = 1; m_armed = 0;
            m_addr = 2'(port_of(cpu_addr));
            m_wr = !cpu_wr_n;
            if (!cpu_wr_n) m_din = cpu_dout;
          end
        end else begin
          m_k++;
          if (m_k == 1) begin
            if (!m_wr) m_cap = daisy_dout;
            m_hit = !m_wr;
            if (WX > 0) m_wait_n = 0;
          end else if (m_k <= 1 + WX) begin
            if (m_k == 1 + WX) m_wait_n = 1;
          end else if (cpu_iorq_n) begin
            m_busy = 0; m_sel = 0; m_hit = 0;
          end
        end
        if (cpu_iorq_n) m_armed = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_sys);
      if (started)
        check("cycle", {10'd0, sel, address, wr, din, cpu_din, cpu_hit, cpu_wait_n},
              {10'd0, m_sel, m_addr, m_wr, m_din, (m_hit ? m_cap : 8'hFF), m_hit, m_wait_n});
    end
  end

  // ---------------- observation counters ----------------
  int   sel_rises = 0, sel_ticks = 0, wait_ticks = 0;
  logic prev_sel = 1'b0;

  initial begin
    forever begin
      @(negedge clk_sys);
      if (sel === 1'b1 && prev_sel === 1'b0) sel_rises++;
      prev_sel = sel;
    end
  end

  initial begin
    forever begin
      @(posedge clk_sys);
      if (ce && !reset) begin
        if (sel === 1'b1) sel_ticks++;
        if (cpu_wait_n === 1'b0) wait_ticks++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    do @(posedge clk_sys); while (ce !== 1'b1);
    @(negedge clk_sys);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_io(input logic [15:0] a, input bit is_wr, input logic [7:0] d);
    cpu_addr   = a;
    cpu_dout   = d;
    cpu_m1_n   = 1'b1;
    cpu_rd_n   = is_wr;
    cpu_wr_n   = !is_wr;
    cpu_iorq_n = 1'b0;
  endtask

  task automatic release_io();
    cpu_iorq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
    cpu_m1_n   = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_addr"}, 32'(address), 32'd0);
    check({tag, "_wr"}, 32'(wr), 32'd0);
    check({tag, "_din"}, 32'(din), 32'h00);
    check({tag, "_cpu_din"}, 32'(cpu_din), 32'hFF);
    check({tag, "_hit"}, 32'(cpu_hit), 32'd0);
    check({tag, "_wait_n"}, 32'(cpu_wait_n), 32'd1);
  endtask

  int r0, s0, w0;

  initial begin
    reset = 1'b1; cpu_addr = 16'h0000; cpu_dout = 8'h00; daisy_dout = 8'h00;
    release_io();
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    started = 1'b1;
    check_reset_outputs("rst");
    reset = 1'b0;
    run_ticks(2);

    // Write 0x12 to 0x01FC, address wiggled mid-cycle.
    r0 = sel_rises; s0 = sel_ticks;
    drive_io(16'h01FC, 1, 8'h12);
    tick();
    check("w1fc_sel", 32'(sel), 32'd1);
    check("w1fc_addr", 32'(address), 32'd2);
    check("w1fc_wr", 32'(wr), 32'd1);
    check("w1fc_din", 32'(din), 32'h12);
    cpu_addr = 16'h00FD;
    tick();
    check("w1fc_addr_stable", 32'(address), 32'd2);
    release_io();
    run_ticks(WX + 2);
    check("w1fc_rises", 32'(sel_rises - r0), 32'd1);
    check("w1fc_sel_ticks", 32'(sel_ticks - s0), 32'(2 + WX));

    // Read 0x00FD returning 0xE9.
    daisy_dout = 8'hE9;
    drive_io(16'h00FD, 0, 8'h00);
    tick();
    check("rfd_hit_early", 32'(cpu_hit), 32'd0);
    check("rfd_addr", 32'(address), 32'd1);
    tick();
    check("rfd_hit", 32'(cpu_hit), 32'd1);
    check("rfd_data", 32'(cpu_din), 32'hE9);
    daisy_dout = 8'h00;
    run_ticks(2);
    check("rfd_data_held", 32'(cpu_din), 32'hE9);
    release_io();
    run_ticks(WX + 2);
    check("rfd_hit_off", 32'(cpu_hit), 32'd0);
    check("rfd_data_off", 32'(cpu_din), 32'hFF);

    // Interrupt acknowledge on 0x00FC, then read 0x12FC.
    r0 = sel_rises;
    cpu_addr = 16'h00FC; cpu_m1_n = 1'b0; cpu_rd_n = 1'b0; cpu_iorq_n = 1'b0;
    run_ticks(3);
    check("intack_rises", 32'(sel_rises - r0), 32'd0);
    release_io();
    run_ticks(1);
    drive_io(16'h12FC, 0, 8'h00);
    tick();
    check("r12fc_sel", 32'(sel), 32'd1);
    check("r12fc_addr", 32'(address), 32'd0);
    release_io();
    run_ticks(WX + 2);

    // Write 0xAA to 0x00FC: wait-state length and window width.
    s0 = sel_ticks; w0 = wait_ticks;
    drive_io(16'h00FC, 1, 8'hAA);
    tick();
    check("wfc_din", 32'(din), 32'hAA);
    tick();
    release_io();
    run_ticks(WX + 2);
    check("wfc_wait_ticks", 32'(wait_ticks - w0), 32'(WX));
    check("wfc_sel_ticks", 32'(sel_ticks - s0), 32'(2 + WX));
    check("wfc_din_after", 32'(din), 32'hAA);

    // Reset during HOLD of a 0x00FC read, IORQ kept low.
    daisy_dout = 8'h5A;
    drive_io(16'h00FC, 0, 8'h00);
    run_ticks(2 + WX);
    check("hold_sel", 32'(sel), 32'd1);
    reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check_reset_outputs("midrst");
    reset = 1'b0;
    r0 = sel_rises;
    run_ticks(4);
    check("midrst_no_rearm", 32'(sel_rises - r0), 32'd0);
    release_io();
    run_ticks(1);
    drive_io(16'h00FC, 0, 8'h00);
    run_ticks(1);
    check("midrst_rearm", 32'(sel_rises - r0), 32'd1);
    release_io();
    run_ticks(WX + 2);

    // Non-decoded port, rd+wr both low, and a long IORQ on 0x00FD.
    r0 = sel_rises;
    drive_io(16'h00FE, 0, 8'h00);
    run_ticks(3);
    check("rfe_rises", 32'(sel_rises - r0), 32'd0);
    release_io();
    run_ticks(1);
    drive_io(16'h00FC, 1, 8'h33);
    cpu_rd_n = 1'b0;
    run_ticks(3);
    check("rdwr_rises", 32'(sel_rises - r0), 32'd0);
    release_io();
    run_ticks(1);
    drive_io(16'h00FD, 0, 8'h00);
    run_ticks(10);
    check("long_sel", 32'(sel), 32'd1);
    release_io();
    run_ticks(WX + 2);
    check("long_rises", 32'(sel_rises - r0), 32'd1);
    check("long_sel_off", 32'(sel), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/daisy_io_decoder.md
# daisy_io_decoder

Z80 I/O-cycle tracker that sits directly upstream of the daisywheel/printer controller emulation. It decodes CPU I/O cycles to ports 0x00FC, 0x00FD and 0x01FC, and presents each as one stable, glitch-free select window with a latched 2-bit port code, direction and write data. It captures the controller's read data and returns it to the CPU data bus, and can optionally stretch the cycle with Z80 wait states.

## Interface
Parameters:
- `WAIT_STATES`, default 2: number of `ce` ticks that `cpu_wait_n` is held low per decoded access. Used only with `DAISY_WAIT_EN`. Legal range 1..15.

Ports:
- `clk_sys`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `ce`  in  1  CPU clock enable; every state change is qualified by `ce`
- `cpu_addr`  in  16  Z80 address bus
- `cpu_dout`  in  8  Z80 write data
- `cpu_iorq_n`, `cpu_rd_n`, `cpu_wr_n`, `cpu_m1_n`  in  1 each  Z80 strobes, active-low
- `sel`  out  1  select to controller
- `address`  out  2  port code to controller: 00 = FC, 01 = FD, 10 = 1FC
- `wr`  out  1  1 = write, 0 = read
- `din`  out  8  latched write data to controller
- `daisy_dout`  in  8  controller read data
- `cpu_din`  out  8  read data returned to the CPU
- `cpu_hit`  out  1  high while `cpu_din` is valid for a decoded read (bus mux enable)
- `cpu_wait_n`  out  1  Z80 WAIT, active-low

## Operation
Port decode, evaluated on the sampled address:
- `cpu_addr` == 0x01FC gives code 10.
- Otherwise, `cpu_addr[7:0]` == 0xFC gives code 00.
- `cpu_addr[7:0]` == 0xFD gives code 01; the high byte is ignored.
- Any other address is no hit.

A cycle starts on a `ce` tick in IDLE when all of the following hold: `cpu_iorq_n`=0, `cpu_m1_n`=1, exactly one of `cpu_rd_n`/`cpu_wr_n` is 0, the address decodes to a hit, and `armed`=1.
- Interrupt-acknowledge cycles (M1 and IORQ both low) are ignored.
- If `rd_n` and `wr_n` are both low, the cycle is ignored.

State machine:
- IDLE: `sel`=0. A start condition latches `address`, `wr` (= `~cpu_wr_n`) and, for writes, `din` (= `cpu_dout`), then goes to ACCESS.
- ACCESS: lasts exactly one `ce` tick, with `sel`=1. On that tick a read latches `cpu_din` from `daisy_dout`. Next state is WAIT when `DAISY_WAIT_EN` is defined, otherwise HOLD.
- WAIT: `sel`=1 and `cpu_wait_n`=0. The counter loads `WAIT_STATES-1` on entry and decrements each `ce`. At 0 the next state is HOLD.
- HOLD: `sel`=1. On the first `ce` tick with `cpu_iorq_n`=1 the state goes to IDLE and `sel` drops.

Behaviour held for the whole cycle:
- `address`, `wr` and `din` stay stable while `sel`=1, so the downstream edge detector fires exactly once per CPU cycle.
- `cpu_hit` = `sel` & ~`wr` from ACCESS+1 through HOLD. `cpu_din` holds its captured value until the next capture.
- When `cpu_hit`=0, `cpu_din` = 0xFF.

`armed` flag:
- Set on any `ce` tick where `cpu_iorq_n`=1.
- Cleared when a cycle starts.
- This guarantees one access per IORQ assertion, including after reset.

Boundary conditions:
- If `cpu_iorq_n` rises during WAIT (an illegal CPU cycle), the wait count finishes, then HOLD exits on the next tick.
- The address is sampled only at start. Address changes mid-cycle are ignored.

## Timing
- Reset values: `sel`=0, `address`=00, `wr`=0, `din`=0x00, `cpu_din`=0xFF, `cpu_hit`=0, `cpu_wait_n`=1, state IDLE, counter 0, `armed`=0.
- Start sampled on `ce` tick N: `sel`, `address`, `wr` and `din` are valid from `clk_sys` N+1.
- Read data: captured on `ce` tick N+1 (ACCESS). `cpu_hit` is high from `clk_sys` N+2.
- Minimum `sel` width: 2 `ce` ticks without waits; 2+`WAIT_STATES` with waits.
- `cpu_wait_n` goes low one `clk_sys` after ACCESS and returns high on the tick the counter hits 0.
- Reset mid-cycle: all outputs return to reset values on the next clock. No access resumes until IORQ is seen high.
- With `ce`=0, nothing changes.

## Configuration
- `DAISY_WAIT_EN` defined: WAIT state and counter are built, and `cpu_wait_n` asserts as above.
- Not defined: WAIT state and counter are removed, ACCESS goes directly to HOLD, and `cpu_wait_n` is tied to 1.

## Structure
- Shared package `pcw_io_pkg`:
  - port-code enum `daisy_port_t` (PORT_FC=2'b00, PORT_FD=2'b01, PORT_1FC=2'b10)
  - address constants 16'h00FC, 8'hFD and 16'h01FC
  - state enum {IDLE, ACCESS, WAIT, HOLD}
- One sub-module, `io_port_match`: purely combinational decode of `cpu_addr` to {hit, code}, reusable by other PCW port decoders. Everything else stays in this module.

## Test plan
- Write 0x12 to 0x01FC → `sel` high for 2 `ce` ticks plus the IORQ hold, `address`=10, `wr`=1, `din`=0x12; exactly one rising edge of `sel`.
- Read 0x00FD with `daisy_dout`=0xE9 → `cpu_din`=0xE9 and `cpu_hit`=1 from ACCESS+1 until IORQ rises; then `cpu_din`=0xFF.
- IORQ+M1 low with `cpu_addr`=0x00FC (interrupt acknowledge), then read 0x12FC → first is ignored (`sel` stays 0); second gives `address`=00.
- `DAISY_WAIT_EN`, `WAIT_STATES`=3, write 0xAA to 0x00FC → `cpu_wait_n` low for exactly 3 `ce` ticks, `sel` high for 5 ticks, `din`=0xAA throughout.
- Assert `reset` during HOLD of a 0x00FC read, keeping IORQ low → all outputs at reset values, no new `sel` until IORQ goes high and then low again.
- Read 0x00FE, and IORQ held low for 10 ticks on 0x00FD → no `sel` for 0x00FE; a single access for 0x00FD.
